// File: rtl/cam_soc_sysid_pkg.sv
// Shared types and constants for the system-ID checker and its Avalon read master.
package cam_soc_sysid_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned STALL_W = 8;
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_EVAL,
    ST_FINISH
  } sysid_state_e;

  typedef enum logic [1:0] {
    RM_IDLE,
    RM_READ,
    RM_DROP
  } rm_state_e;

  localparam logic [ERR_W-1:0] ERR_NONE    = ERR_W'(0);
  localparam logic [ERR_W-1:0] ERR_ID      = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_TS      = ERR_W'(2);
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = ERR_W'(3);

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef struct packed {
    logic             pass;
    logic [ERR_W-1:0] err_code;
  } sysid_result_t;

  // ID mismatch outranks timestamp mismatch.
  function automatic sysid_result_t sysid_eval(input logic [DATA_W-1:0] id,
                                               input logic [DATA_W-1:0] ts,
                                               input logic [DATA_W-1:0] exp_id,
                                               input logic [DATA_W-1:0] exp_ts,
                                               input logic              check_ts);
    sysid_result_t r;
    r.pass     = 1'b0;
    r.err_code = ERR_NONE;
    if (id != exp_id) begin
      r.err_code = ERR_ID;
    end else if (check_ts && (ts != exp_ts)) begin
      r.err_code = ERR_TS;
    end else begin
      r.pass = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cam_soc_sysid_read_master.sv
// Single Avalon-MM read with waitrequest stall counter, timeout and bounded re-issue.
// After an accepted read, done_o pulses in the following cycle while avm_read_o is low.
module cam_soc_sysid_read_master
  import cam_soc_sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic go_i,
  input  logic addr_i,
  input  logic avm_waitrequest_i,
  output logic avm_read_o,
  output logic avm_address_o,
  output logic done_o,
  output logic accept_c_o,
  output logic fail_c_o
);

  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  rm_state_e            state_q, state_d;
  logic                 read_q, read_d;
  logic                 addr_q, addr_d;
  logic                 done_q, done_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 timeout_c;

  assign accept_c_o = read_q & ~avm_waitrequest_i;
  assign timeout_c  = read_q & avm_waitrequest_i & (stall_q == STALL_LAST);
  assign fail_c_o   = timeout_c & (retry_q >= RETRY_MAX);

  assign avm_read_o    = read_q;
  assign avm_address_o = addr_q;
  assign done_o        = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RM_IDLE;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      stall_q <= stall_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    stall_d = stall_q;
    retry_d = retry_q;
    case (state_q)
      RM_IDLE: begin
        if (go_i) begin
          state_d = RM_READ;
          read_d  = 1'b1;
          addr_d  = addr_i;
          stall_d = '0;
          retry_d = '0;
        end
      end
      RM_READ: begin
        if (accept_c_o) begin
          state_d = RM_IDLE;
          read_d  = 1'b0;
          done_d  = 1'b1;
          stall_d = '0;
        end else if (timeout_c) begin
          read_d  = 1'b0;
          stall_d = '0;
          if (fail_c_o) begin
            state_d = RM_IDLE;
          end else begin
            state_d = RM_DROP;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      RM_DROP: begin
        // One idle cycle has elapsed; re-issue the same address.
        state_d = RM_READ;
        read_d  = 1'b1;
      end
      default: begin
        state_d = RM_IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cam_soc_sysid_checker.sv
// Reads the system ID (and, with SYSID_CHECK_TS_EN defined, the timestamp) word over
// Avalon-MM, compares against expected values and reports a sticky pass / error code.
module cam_soc_sysid_checker
  import cam_soc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1461113250,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

`ifdef SYSID_CHECK_TS_EN
  localparam logic CHECK_TS = 1'b1;
`else
  localparam logic CHECK_TS = 1'b0;
`endif

  sysid_state_e        state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [DATA_W-1:0]   captured_id_q, captured_id_d;
  logic [DATA_W-1:0]   captured_ts_q, captured_ts_d;
  logic                rd_go;
  logic                rd_addr;
  logic                rd_done;
  logic                rd_accept_c;
  logic                rd_fail_c;
  sysid_result_t       eval_res;

  cam_soc_sysid_read_master #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_rd (
    .clock             (clock),
    .reset_n           (reset_n),
    .go_i              (rd_go),
    .addr_i            (rd_addr),
    .avm_waitrequest_i (avm_waitrequest),
    .avm_read_o        (avm_read),
    .avm_address_o     (avm_address),
    .done_o            (rd_done),
    .accept_c_o        (rd_accept_c),
    .fail_c_o          (rd_fail_c)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_code    = err_q;
  assign captured_id = captured_id_q;
  assign captured_ts = captured_ts_q;

  assign eval_res = sysid_eval(captured_id_q, captured_ts_q, EXPECTED_ID, EXPECTED_TS, CHECK_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= ERR_NONE;
      captured_id_q <= '0;
      captured_ts_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
      captured_id_q <= captured_id_d;
      captured_ts_q <= captured_ts_d;
    end
  end

  // The ID read advances on the master's post-accept pulse, which is the idle gap
  // separating the two reads; the TS read advances straight on acceptance.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    err_d         = err_q;
    captured_id_d = captured_id_q;
    captured_ts_d = captured_ts_q;
    rd_go         = 1'b0;
    rd_addr       = SYSID_ADDR_ID;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD_ID;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = ERR_NONE;
          rd_go   = 1'b1;
        end
      end
      ST_RD_ID: begin
        if (rd_accept_c) begin
          captured_id_d = avm_readdata;
        end
        if (rd_fail_c) begin
          state_d = ST_FINISH;
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
        end else if (rd_done) begin
`ifdef SYSID_CHECK_TS_EN
          state_d = ST_RD_TS;
          rd_go   = 1'b1;
          rd_addr = SYSID_ADDR_TS;
`else
          state_d = ST_EVAL;
`endif
        end
      end
`ifdef SYSID_CHECK_TS_EN
      ST_RD_TS: begin
        if (rd_accept_c) begin
          captured_ts_d = avm_readdata;
          state_d       = ST_EVAL;
        end else if (rd_fail_c) begin
          state_d = ST_FINISH;
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
        end
      end
`endif
      ST_EVAL: begin
        pass_d  = eval_res.pass;
        err_d   = eval_res.err_code;
        state_d = ST_FINISH;
        done_d  = 1'b1;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cam_soc_sysid_checker.sv
// Scoreboarded bench for cam_soc_sysid_checker with a stallable zero-latency Avalon slave.
// Expectations follow SYSID_CHECK_TS_EN the same way the design build does.
module tb_cam_soc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1461113250;
  localparam int          TMO    = 16;
  localparam int          RETR   = 2;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [31:0] mem_id = 32'd0;
  logic [31:0] mem_ts = 32'd0;
  int          stall_n = 0;
  bit          stuck = 1'b0;
  int          scnt = 0;

  logic acc_q[$];
  int   rd_cycles = 0;
  int   rd_rises = 0;
  int   addr_changes = 0;
  int   done_cnt = 0;
  logic rd_prev = 1'b0;
  logic addr_prev = 1'b0;

  typedef struct {
    logic        pass;
    logic [1:0]  err;
    logic [31:0] id;
    logic [31:0] ts;
    int          lat;
    int          nrd;
  } exp_t;
  exp_t sb_q[$];

  cam_soc_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (RETR)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_code        (err_code),
    .captured_id     (captured_id),
    .captured_ts     (captured_ts)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave: stalls each read for stall_n cycles (or forever when stuck).
  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) scnt <= scnt + 1;
    else scnt <= 0;
  end
  assign avm_waitrequest = avm_read && (stuck || (scnt < stall_n));
  assign avm_readdata    = avm_address ? mem_ts : mem_id;

  always @(negedge clock) begin
    if (!reset_n) begin
      rd_prev = 1'b0;
    end else begin
      if (avm_read && !avm_waitrequest) acc_q.push_back(avm_address);
      if (avm_read) rd_cycles++;
      if (avm_read && !rd_prev) rd_rises++;
      if (avm_read && rd_prev && (avm_address != addr_prev)) addr_changes++;
      if (done) done_cnt++;
      rd_prev   = avm_read;
      addr_prev = avm_address;
    end
  end

  function automatic exp_t model(input logic [31:0] id, input logic [31:0] ts, input int stall);
    exp_t e;
    e.id  = id;
    e.ts  = TS_EN ? ts : 32'd0;
    e.nrd = TS_EN ? 2 : 1;
    e.lat = TS_EN ? (5 + 2 * stall) : (4 + stall);
    if (id != EXP_ID) begin
      e.pass = 1'b0; e.err = 2'd1;
    end else if (TS_EN && (ts != EXP_TS)) begin
      e.pass = 1'b0; e.err = 2'd2;
    end else begin
      e.pass = 1'b1; e.err = 2'd0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic launch(input logic [31:0] id, input logic [31:0] ts, input int stall, input bit push);
    mem_id  = id;
    mem_ts  = ts;
    stall_n = stall;
    acc_q.delete();
    rd_cycles = 0;
    rd_rises = 0;
    addr_changes = 0;
    if (push) sb_q.push_back(model(id, ts, stall));
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit seen);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1'b1;
        lat  = cyc - t0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL reset avm_read: got %b want 0", avm_read); end
    n_checks++; if (avm_address !== 1'b0) begin n_fail++; $display("FAIL reset avm_address: got %b want 0", avm_address); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset pass: got %b want 0", pass); end
    n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset err_code: got %0d want 0", err_code); end
    n_checks++; if (captured_id !== 32'd0) begin n_fail++; $display("FAIL reset captured_id: got %h want 0", captured_id); end
    n_checks++; if (captured_ts !== 32'd0) begin n_fail++; $display("FAIL reset captured_ts: got %h want 0", captured_ts); end
    reset_n = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || avm_read !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy/read: got %b/%b want 0/0", busy, avm_read); end
  endtask

  task automatic test_compare_words();
    logic [31:0] ids [5];
    logic [31:0] tss [5];
    exp_t e;
    int   lat;
    bit   seen;
    ids = '{EXP_ID, 32'hDEADBEEF, EXP_ID,       32'hDEADBEEF, 32'h0000_0001};
    tss = '{EXP_TS, EXP_TS,       32'h1234_5678, 32'd0,        EXP_TS};
    for (int i = 0; i < 5; i++) begin
      launch(ids[i], tss[i], 0, 1'b1);
      wait_done(lat, seen);
      e = sb_q.pop_front();
      n_checks++; if (!seen) begin n_fail++; $display("FAIL words[%0d] done: no done pulse within bound", i); end
      n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL words[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_checks++; if (pass !== e.pass) begin n_fail++; $display("FAIL words[%0d] pass: got %b want %b", i, pass, e.pass); end
      n_checks++; if (err_code !== e.err) begin n_fail++; $display("FAIL words[%0d] err_code: got %0d want %0d", i, err_code, e.err); end
      n_checks++; if (captured_id !== e.id) begin n_fail++; $display("FAIL words[%0d] captured_id: got %h want %h", i, captured_id, e.id); end
      n_checks++; if (captured_ts !== e.ts) begin n_fail++; $display("FAIL words[%0d] captured_ts: got %h want %h", i, captured_ts, e.ts); end
      n_checks++;
      if (acc_q.size() != e.nrd) begin
        n_fail++; $display("FAIL words[%0d] read_count: got %0d want %0d", i, acc_q.size(), e.nrd);
      end else if (acc_q[0] !== 1'b0 || acc_q[e.nrd-1] !== TS_EN) begin
        n_fail++; $display("FAIL words[%0d] address_order: got first %b last %b want 0 then %b", i, acc_q[0], acc_q[e.nrd-1], TS_EN);
      end
      n_checks++; if (rd_cycles != e.nrd) begin n_fail++; $display("FAIL words[%0d] read_cycles: got %0d want %0d", i, rd_cycles, e.nrd); end
      tick();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL words[%0d] post_finish busy/done: got %b/%b want 0/0", i, busy, done); end
      tick();
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   lat;
    bit   seen;
    launch(EXP_ID, EXP_TS, 3, 1'b1);
    wait_done(lat, seen);
    e = sb_q.pop_front();
    n_checks++; if (!seen || lat != e.lat) begin n_fail++; $display("FAIL stall latency: got %0d (seen %b) want %0d", lat, seen, e.lat); end
    n_checks++; if (pass !== 1'b1 || err_code !== 2'd0) begin n_fail++; $display("FAIL stall result pass/err: got %b/%0d want 1/0", pass, err_code); end
    n_checks++; if (addr_changes != 0) begin n_fail++; $display("FAIL stall address_stable: got %0d changes want 0", addr_changes); end
    n_checks++; if (rd_cycles != 4 * e.nrd || rd_rises != e.nrd) begin n_fail++; $display("FAIL stall read_shape: got %0d cycles %0d rises want %0d/%0d", rd_cycles, rd_rises, 4 * e.nrd, e.nrd); end
    n_checks++; if (acc_q.size() != e.nrd) begin n_fail++; $display("FAIL stall accepts: got %0d want %0d", acc_q.size(), e.nrd); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   lat;
    bit   seen;
    stuck = 1'b1;
    e.pass = 1'b0; e.err = 2'd3; e.id = 32'd0; e.ts = 32'd0; e.nrd = 0;
    e.lat  = (RETR + 1) * TMO + RETR + 1;
    sb_q.push_back(e);
    launch(EXP_ID, EXP_TS, 0, 1'b0);
    wait_done(lat, seen);
    e = sb_q.pop_front();
    n_checks++; if (!seen || lat != e.lat) begin n_fail++; $display("FAIL timeout latency: got %0d (seen %b) want %0d", lat, seen, e.lat); end
    n_checks++; if (err_code !== e.err) begin n_fail++; $display("FAIL timeout err_code: got %0d want %0d", err_code, e.err); end
    n_checks++; if (pass !== e.pass) begin n_fail++; $display("FAIL timeout pass: got %b want %b", pass, e.pass); end
    n_checks++; if (rd_rises != RETR + 1) begin n_fail++; $display("FAIL timeout attempts: got %0d want %0d", rd_rises, RETR + 1); end
    n_checks++; if (rd_cycles != (RETR + 1) * TMO) begin n_fail++; $display("FAIL timeout stall_cycles: got %0d want %0d", rd_cycles, (RETR + 1) * TMO); end
    n_checks++; if (addr_changes != 0 || acc_q.size() != 0) begin n_fail++; $display("FAIL timeout address/accepts: got %0d/%0d want 0/0", addr_changes, acc_q.size()); end
    stuck = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    exp_t e;
    int   lat;
    int   snap;
    bit   seen;
    bit   found = 1'b0;
    launch(EXP_ID, EXP_TS, 10, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (avm_read && (avm_address == TS_EN)) begin found = 1'b1; break; end
      tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reset_mid reach_last_read: read of address %b never seen", TS_EN); end
    tick();
    snap = done_cnt;
    reset_n = 1'b0;
    #1;
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL reset_mid avm_read: got %b want 0", avm_read); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || avm_address !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy/done/addr: got %b/%b/%b want 0/0/0", busy, done, avm_address); end
    n_checks++; if (pass !== 1'b0 || err_code !== 2'd0 || captured_ts !== 32'd0) begin n_fail++; $display("FAIL reset_mid pass/err/ts: got %b/%0d/%h want 0/0/0", pass, err_code, captured_ts); end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    n_checks++; if (done_cnt != snap || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid no_done_after_release: got %0d dones busy %b want 0 dones busy 0", done_cnt - snap, busy); end
    launch(EXP_ID, EXP_TS, 0, 1'b1);
    wait_done(lat, seen);
    e = sb_q.pop_front();
    n_checks++; if (!seen || lat != e.lat || pass !== 1'b1 || err_code !== 2'd0) begin n_fail++; $display("FAIL reset_mid rerun: got lat %0d pass %b err %0d want lat %0d pass 1 err 0", lat, pass, err_code, e.lat); end
    tick(); tick();
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int   lat;
    int   snap;
    bit   seen;
    snap = done_cnt;
    launch(EXP_ID, EXP_TS, 0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, seen);
    e = sb_q.pop_front();
    n_checks++; if (!seen || lat != e.lat) begin n_fail++; $display("FAIL start_busy latency: got %0d (seen %b) want %0d", lat, seen, e.lat); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL start_in_finish busy/done: got %b/%b want 0/0", busy, done); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (done_cnt != snap + 1) begin n_fail++; $display("FAIL start_ignored done_pulses: got %0d want 1", done_cnt - snap); end
    n_checks++; if (rd_rises != e.nrd || busy !== 1'b0) begin n_fail++; $display("FAIL start_ignored reads/busy: got %0d/%b want %0d/0", rd_rises, busy, e.nrd); end
  endtask

  initial begin
    test_reset();
    test_compare_words();
    test_stall();
    test_timeout();
    test_reset_mid_read();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

endmodule

// File: doc/cam_soc_sysid_checker.md
CAM_SOC_SYSID_CHECKER -- requirements
Module: cam_soc_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0: required system ID word.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1461113250: required timestamp word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum waitrequest-stalled cycles per read, range 1..255.
REQ-004 SHALL have parameter MAX_RETRIES, default 2: re-issues of a timed-out read before failing, range 0..7.
REQ-005 Ports SHALL be: clock  in  1  single clock, all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse, begins a check sequence.
REQ-008 avm_address  out  1  Avalon-MM word address: 0 = ID, 1 = timestamp.
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_readdata  in  32  Avalon-MM read data.
REQ-011 avm_waitrequest  in  1  slave stall; tie 0 for zero-wait slaves.
REQ-012 busy  out  1  sequence in progress.
REQ-013 done  out  1  one-cycle pulse at sequence end.
REQ-014 pass  out  1  sticky result: all compared words matched.
REQ-015 err_code  out  2  sticky: 0 none, 1 ID mismatch, 2 TS mismatch, 3 timeout.
REQ-016 captured_id, captured_ts  out  32 each  last words read.

Function
REQ-017 FSM states SHALL be IDLE, RD_ID, RD_TS, EVAL, FINISH.
REQ-018 IDLE: start=1 -> RD_ID next cycle; clear pass, err_code, retry count; busy=1 from that cycle.
REQ-019 RD_x: avm_read=1 with avm_address constant (0 in RD_ID, 1 in RD_TS) until a cycle with avm_waitrequest=0.
REQ-020 Data SHALL be sampled into captured_x in the same cycle avm_waitrequest=0 (zero read latency, no readdatavalid).
REQ-021 RD_ID accept -> RD_TS; RD_TS accept -> EVAL; avm_read SHALL deassert for at least one cycle between the two reads.
REQ-022 Stall counter SHALL count cycles with avm_waitrequest=1; reaching TIMEOUT_CYCLES SHALL drop avm_read for one cycle and re-issue the same read while retries < MAX_RETRIES, else go to FINISH with err_code=3.
REQ-023 Stall counter SHALL reset to 0 on every accepted read and every re-issue.
REQ-024 EVAL (one cycle): ID mismatch -> err_code=1; else TS mismatch -> err_code=2; else pass=1; ID error takes priority.
REQ-025 FINISH: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
REQ-026 start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-027 Total latency with zero waitrequest: done asserts 5 cycles after the start cycle.

Reset
REQ-028 On reset_n=0, state SHALL go to IDLE immediately; avm_read, avm_address, busy, done, pass, err_code, captured_id, captured_ts, counters SHALL be 0.
REQ-029 Reset mid-read SHALL drop avm_read asynchronously; no done pulse SHALL follow release.

Configuration
REQ-030 Macro SYSID_CHECK_TS_EN defined: behaviour as above.
REQ-031 Macro SYSID_CHECK_TS_EN undefined: RD_TS omitted, RD_ID accept -> EVAL, captured_ts tied 0, err_code 2 never produced, zero-wait latency 4 cycles.

Structure
REQ-032 Shared package cam_soc_sysid_pkg SHALL hold the state enum, err_code constants, and address constants SYSID_ADDR_ID=0, SYSID_ADDR_TS=1.
REQ-033 One sub-module SHALL be natural: cam_soc_sysid_read_master, owning a single Avalon read with stall counter and retry.

Verification
REQ-034 Zero-wait slave returning 0 / 1461113250, start pulse -> done 5 cycles later, pass=1, err_code=0, avm_address sequence 0 then 1.
REQ-035 Slave returning 32'hDEADBEEF at address 0 -> pass=0, err_code=1, captured_id=32'hDEADBEEF.
REQ-036 avm_waitrequest=1 for 3 cycles on each read -> pass=1, done 11 cycles after start, avm_address stable during stalls.
REQ-037 avm_waitrequest stuck 1, defaults -> 3 read attempts of 16 stall cycles each, then done with err_code=3, pass=0.
REQ-038 reset_n pulsed low during RD_TS stall -> all outputs 0 at once, no done after release; next start passes.
REQ-039 Build without SYSID_CHECK_TS_EN, timestamp word wrong -> pass=1, only address 0 read, done 4 cycles after start.
